// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache (read-only)
// and the D-cache (read/write); one line transfer in flight at a time.
module pmem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LINE_W      = 128,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e state_q;
  logic   last_d_q;  // 1: D-cache held the most recent grant
  logic   d_req;
  logic   d_wins;

  assign d_req  = d_read | d_write;
  // D takes the port unless I is also asking and round-robin says it is I's turn.
  assign d_wins = d_req & (~i_read | ~ROUND_ROBIN | ~last_d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (d_wins) begin
            state_q  <= StServeD;
            last_d_q <= 1'b1;
          end else if (i_read) begin
            state_q  <= StServeI;
            last_d_q <= 1'b0;
          end
        end
        StServeI, StServeD: begin
          if (pmem_resp) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      StServeI: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      StServeD: begin
        // A simultaneous read and write is treated as a writeback.
        pmem_write   = d_write;
        pmem_read    = ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule
